// File: rtl/multu_accum.sv
// multu_accum: multiply-accumulate back end for the unsigned multiplier.
// Sums `len` unsigned product beats received over a valid/ready stream and
// presents the total on a held valid/ready result port.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds valid and its data
// stable until that transfer; the result port holds out_valid/out until
// out_ready is seen.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, len           begin a run of len terms (sampled only in IDLE)
//   busy                 high while a run is in ACCUM or DONE
//   in_valid/in_ready/in_data    product stream (PW bits)
//   out_valid/out_ready/out      result (SW = PW+GW bits)
//   ovf                  sticky carry-out flag for the current run
//   dbg_state            FSM state (0 IDLE, 1 ACCUM, 2 DONE)
//
// Build option: define MULTU_ACCUM_SAT_EN to saturate the sum at 2^SW-1 on
// carry-out; otherwise the sum wraps modulo 2^SW (ovf is set in both cases).
module multu_accum #(
  parameter int PW = 16,
  parameter int CW = 8,
  parameter int GW = 8,
  parameter int SW = PW + GW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] len,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out,
  output logic          ovf,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [SW:0]   sum;
  logic [SW-1:0] next_acc;

  // One extra bit catches the carry-out that drives ovf.
  assign sum = {1'b0, acc} + (SW+1)'(in_data);

  always_comb begin
    next_acc = sum[SW-1:0];
`ifdef MULTU_ACCUM_SAT_EN
    // Once saturated, any further add carries out again (or adds 0),
    // so the value stays pinned at all-ones for the rest of the run.
    if (sum[SW]) next_acc = '1;
`else
    next_acc = sum[SW-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            ovf <= 1'b0;
            if (len == '0) begin
              state <= DONE;
            end else begin
              cnt   <= len;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          // in_ready is high for the whole state, so in_valid alone
          // qualifies a transfer here.
          if (in_valid) begin
            acc <= next_acc;
            cnt <= cnt - 1'b1;
            if (sum[SW]) ovf <= 1'b1;
            // Leaving at cnt==1 means cnt never wraps below zero.
            if (cnt == CW'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  // acc is only cleared on start, so in IDLE it still holds the last result.
  assign out       = acc;
  assign dbg_state = state;

endmodule

// File: tb/tb_multu_accum.sv
module tb_multu_accum;

  localparam int PW = 16;
  localparam int CW = 8;
  localparam int GW = 8;
  localparam int SW = PW + GW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out;
  logic          ovf;
  logic [1:0]    dbg_state;

  // zero-guard instance (GW=0) for the overflow case
  logic          g_start = 1'b0;
  logic [CW-1:0] g_len = '0;
  logic          g_busy;
  logic          g_in_valid = 1'b0;
  logic          g_in_ready;
  logic [PW-1:0] g_in_data = '0;
  logic          g_out_valid;
  logic          g_out_ready = 1'b0;
  logic [PW-1:0] g_out;
  logic          g_ovf;
  logic [1:0]    g_dbg_state;

  multu_accum #(.PW(PW), .CW(CW), .GW(GW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  multu_accum #(.PW(PW), .CW(CW), .GW(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .start(g_start), .len(g_len), .busy(g_busy),
    .in_valid(g_in_valid), .in_ready(g_in_ready), .in_data(g_in_data),
    .out_valid(g_out_valid), .out_ready(g_out_ready), .out(g_out), .ovf(g_ovf),
    .dbg_state(g_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving and sampling happens at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Idle `gap` cycles, then present one beat for one cycle.
  task automatic send_beat(input logic [PW-1:0] d, input int gap);
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    check("in_ready_before_beat", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_run(input logic [CW-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  logic [PW-1:0] exp_g_out;

  initial begin
    // ---- reset state ----
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- 1: len=4, back-to-back 3,5,7,9 ----
    out_ready = 1'b1;
    start_run(8'd4);
    check("t1_busy", {31'b0, busy}, 32'd1);
    send_beat(16'd3, 0);
    send_beat(16'd5, 0);
    send_beat(16'd7, 0);
    send_beat(16'd9, 0);
    check("t1_out_valid", {31'b0, out_valid}, 32'd1);
    check("t1_out", 32'(out), 32'd24);
    check("t1_ovf", {31'b0, ovf}, 32'd0);
    check("t1_in_ready_done", {31'b0, in_ready}, 32'd0);
    tick();
    check("t1_busy_after", {31'b0, busy}, 32'd0);
    check("t1_out_valid_after", {31'b0, out_valid}, 32'd0);
    check("t1_out_hold", 32'(out), 32'd24);

    // ---- 2: gaps, consumer stall ----
    out_ready = 1'b0;
    start_run(8'd3);
    send_beat(16'd100, 0);
    send_beat(16'd200, 2);
    send_beat(16'd300, 2);
    check("t2_in_ready_done", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", {31'b0, out_valid}, 32'd1);
      check("t2_stall_out", 32'(out), 32'd600);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t2_idle_busy", {31'b0, busy}, 32'd0);
    check("t2_idle_out", 32'(out), 32'd600);

    // ---- 3: len=0 ----
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'd77;
    start_run(8'd0);
    check("t3_out_valid", {31'b0, out_valid}, 32'd1);
    check("t3_out", 32'(out), 32'd0);
    check("t3_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("t3_out_no_consume", 32'(out), 32'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t3_idle_busy", {31'b0, busy}, 32'd0);
    check("t3_idle_out", 32'(out), 32'd0);

    // ---- 4: GW=0 overflow, 0xFFFF + 0x0002 ----
    g_out_ready = 1'b1;
    g_start = 1'b1;
    g_len   = 8'd2;
    tick();
    g_start = 1'b0;
    g_in_valid = 1'b1;
    g_in_data  = 16'hFFFF;
    tick();
    g_in_data  = 16'h0002;
    tick();
    g_in_valid = 1'b0;
`ifdef MULTU_ACCUM_SAT_EN
    exp_g_out = 16'hFFFF;
`else
    exp_g_out = 16'h0001;
`endif
    check("t4_out_valid", {31'b0, g_out_valid}, 32'd1);
    check("t4_out", 32'(g_out), 32'(exp_g_out));
    check("t4_ovf", {31'b0, g_ovf}, 32'd1);
    tick();
    check("t4_idle", {31'b0, g_busy}, 32'd0);

    // ---- 5: async reset mid-run ----
    start_run(8'd5);
    send_beat(16'd11, 0);
    send_beat(16'd22, 0);
    in_valid = 1'b1;
    in_data  = 16'd33;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("t5_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("t5_rst_out", 32'(out), 32'd0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("t5_post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    start_run(8'd1);
    send_beat(16'd42, 0);
    check("t5_out_valid", {31'b0, out_valid}, 32'd1);
    check("t5_out", 32'(out), 32'd42);
    tick();

    // ---- 6: start pulses ignored in ACCUM and DONE ----
    out_ready = 1'b0;
    start_run(8'd2);
    start = 1'b1;
    len   = 8'd7;
    send_beat(16'd10, 0);
    send_beat(16'd20, 0);
    check("t6_out_valid", {31'b0, out_valid}, 32'd1);
    check("t6_out", 32'(out), 32'd30);
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("t6_idle_busy", {31'b0, busy}, 32'd0);
    check("t6_idle_state", 32'(dbg_state), 32'd0);
    tick();
    check("t6_still_idle", {31'b0, busy}, 32'd0);
    check("t6_out_hold", 32'(out), 32'd30);

    // ---- final report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multu_accum.md
Name: multu_accum

Overview:
- Sequential multiply-accumulate back end that sits directly downstream of the unsigned multiplier.
- Consumes a stream of unsigned products over a valid/ready handshake and sums a programmed number of terms (len).
- Presents the total on a held valid/ready output port.
- Typical use: dot products and FIR taps built from one combinational multiplier plus this accumulator.

Parameters:
- PW, 16, product width; equals L1+L2 of the feeding multiplier (8+8 default).
- CW, 8, term-count width; a run holds 0 to 2^CW-1 terms.
- GW, 8, guard bits above PW. Sum width SW = PW+GW. GW>=CW guarantees no overflow.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a run; sampled only in IDLE.
- len, input, CW, number of terms in the run; sampled with start.
- busy, output, 1, high in ACCUM and DONE.
- in_valid, input, 1, product beat valid.
- in_ready, output, 1, block accepts a product this cycle.
- in_data, input, PW, unsigned product from the multiplier.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- out, output, SW, accumulated sum.
- ovf, output, 1, sum exceeded 2^SW-1 during the run.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low. It forces IDLE immediately, including mid-run.
  - All outputs, the accumulator and the counter go to 0.
  - The partial sum is discarded. No result is produced for an aborted run.
  - After reset release, the first legal start is on the first rising edge with rst_n high.
- State IDLE:
  - in_ready=0, out_valid=0, busy=0. out holds the last result (0 after reset).
  - On start=1 with len!=0: clear the accumulator, clear ovf, load remaining count cnt<=len, go to ACCUM.
  - On start=1 with len==0: clear the accumulator and ovf, go directly to DONE. out becomes 0 and out_valid=1 on the next cycle.
- State ACCUM:
  - in_ready=1 and busy=1.
  - A beat transfers when in_valid & in_ready at a rising edge. The beat does acc<=acc+zero-extend(in_data) and cnt<=cnt-1.
  - in_valid low: the accumulator and counter hold.
  - When the transferring beat has cnt==1: go to DONE and drop in_ready for the following cycle.
  - Back-to-back beats are accepted at 1 per cycle.
- State DONE:
  - out_valid=1 and busy=1. out = acc, stable until the handshake completes.
  - in_ready=0; extra product beats are not consumed.
  - On out_valid & out_ready: go to IDLE. out keeps its value.
- Latency and throughput:
  - out_valid rises on the cycle after the last beat's transfer edge.
  - Minimum run = len+2 cycles (start edge, len beat edges, result edge), excluding consumer stall.
- start handling: start is ignored in ACCUM and DONE, including the DONE handshake cycle. A new run needs start in IDLE.
- Arithmetic:
  - Sum width is SW. The add is unsigned, carried out to SW+1 bits internally.
  - ovf is sticky for the run and cleared on start.
  - Without the optional feature the sum wraps modulo 2^SW.
- len is sampled once. Changes to len during a run have no effect.
- cnt never underflows because DONE is entered at cnt==1.

Optional Feature:
- Macro: MULTU_ACCUM_SAT_EN.
- Defined:
  - On carry-out, acc saturates to 2^SW-1 and ovf is set.
  - Further adds in the same run keep acc at 2^SW-1.
- Undefined:
  - acc wraps modulo 2^SW.
  - ovf is still set on carry-out, so overflow remains observable.
  - No saturation logic is synthesised.

Test Plan:
1. Reset then start, len=4, beats 3,5,7,9 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, out=24, ovf=0, busy drops the next cycle.
2. len=3, in_valid gaps of 2 cycles between beats 100,200,300, out_ready held 0 for 5 cycles -> in_ready low after 3rd beat, out=600 held stable with out_valid=1 until out_ready, then IDLE.
3. start with len=0 -> next cycle out_valid=1, out=0; no beats consumed while in_valid=1, in_ready stays 0.
4. GW=0, PW=16, len=2, beats 0xFFFF,0x0002 -> with MULTU_ACCUM_SAT_EN out=0xFFFF, ovf=1; without it out=0x0001, ovf=1.
5. len=5, rst_n low after 2 beats asynchronously (mid-cycle) -> outputs 0 immediately. After release, start len=1, beat 42 -> out=42.
6. start pulsed in ACCUM and DONE during a len=2 run -> ignored; exactly one result produced and the block returns to IDLE.
